// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller state encoding, Key_Expansion command codes,
// the forward S-box and the GF(2^8) helpers used by the round datapath.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LOAD  = 3'b001,
    KWAIT = 3'b010,
    ROUND = 3'b011,
    DONE  = 3'b100
  } state_t;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;
  localparam logic [2:0] KE_IDLE    = 3'b000;
  localparam logic [2:0] KE_LOAD    = 3'b001;
  localparam logic [2:0] KE_RUN     = 3'b010;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Column bytes are MSB first: a0 is row 0.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// Combinational SubBytes -> ShiftRows -> MixColumns on a column-major 128-bit state.
// final_round bypasses MixColumns; AddRoundKey is left to the caller.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [7:0]   sub_bytes [16];
  logic [127:0] shifted;

  // Byte n sits at bits [127-8n -: 8]; n = 4*column + row.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int SRC = 4 * (((gi / 4) + (gi % 4)) % 4) + (gi % 4);
    assign sub_bytes[gi] = SBOX[state_in[127-8*gi -: 8]];
    assign shifted[127-8*gi -: 8] = sub_bytes[SRC];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [31:0] mixed;
    assign mixed = mix_column(shifted[127-32*gi -: 32]);
    assign state_out[127-32*gi -: 32] = final_round ? shifted[127-32*gi -: 32] : mixed;
  end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryptor: sequences an external Key_Expansion block and applies
// one round per KWAIT/ROUND pair, returning the ciphertext with a done pulse.
module aes_cipher_core
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] pt_in_0,
  input  logic [DATA_WIDTH-1:0] pt_in_1,
  input  logic [DATA_WIDTH-1:0] pt_in_2,
  input  logic [DATA_WIDTH-1:0] pt_in_3,
  input  logic [DATA_WIDTH-1:0] key_in_0,
  input  logic [DATA_WIDTH-1:0] key_in_1,
  input  logic [DATA_WIDTH-1:0] key_in_2,
  input  logic [DATA_WIDTH-1:0] key_in_3,
  input  logic [DATA_WIDTH-1:0] rk_in_0,
  input  logic [DATA_WIDTH-1:0] rk_in_1,
  input  logic [DATA_WIDTH-1:0] rk_in_2,
  input  logic [DATA_WIDTH-1:0] rk_in_3,
  output logic [2:0]            ke_fsm_out,
  output logic [3:0]            ke_count_out,
  output logic [DATA_WIDTH-1:0] ke_data_out_0,
  output logic [DATA_WIDTH-1:0] ke_data_out_1,
  output logic [DATA_WIDTH-1:0] ke_data_out_2,
  output logic [DATA_WIDTH-1:0] ke_data_out_3,
  output logic                  ready_out,
  output logic                  done_out,
  output logic [DATA_WIDTH-1:0] ct_out_0,
  output logic [DATA_WIDTH-1:0] ct_out_1,
  output logic [DATA_WIDTH-1:0] ct_out_2,
  output logic [DATA_WIDTH-1:0] ct_out_3
);

  localparam int BW = 4 * DATA_WIDTH;

  state_t          state_reg, state_next;
  logic [BW-1:0]   data_reg;
  logic [BW-1:0]   key_reg;
  logic [BW-1:0]   ct_reg;
  logic [3:0]      round_reg;
  logic            done_reg;
  logic [BW-1:0]   round_key;
  logic [BW-1:0]   round_out;
  logic [BW-1:0]   round_result;
  logic            final_round;

  assign round_key   = {rk_in_0, rk_in_1, rk_in_2, rk_in_3};
  assign final_round = (round_reg == NUM_ROUNDS);

  aes_round_comb u_round (
    .state_in    (data_reg),
    .final_round (final_round),
    .state_out   (round_out)
  );

  // Round 0 is the initial AddRoundKey only.
  assign round_result = ((round_reg == 4'd0) ? data_reg : round_out) ^ round_key;

  always_comb begin
    state_next = state_reg;
    ke_fsm_out = KE_IDLE;
    case (state_reg)
      IDLE:  if (start_in) state_next = LOAD;
      LOAD:  begin
        ke_fsm_out = KE_LOAD;
        state_next = KWAIT;
      end
      KWAIT: begin
        ke_fsm_out = KE_RUN;
        state_next = ROUND;
      end
      ROUND: begin
        ke_fsm_out = KE_RUN;
        state_next = final_round ? DONE : KWAIT;
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      key_reg   <= '0;
      ct_reg    <= '0;
      round_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: if (start_in) begin
          data_reg <= {pt_in_0, pt_in_1, pt_in_2, pt_in_3};
          key_reg  <= {key_in_0, key_in_1, key_in_2, key_in_3};
        end
        // The round counter doubles as ke_count_out, so it only moves here.
        ROUND: begin
          data_reg  <= round_result;
          round_reg <= final_round ? 4'd0 : round_reg + 4'd1;
        end
        DONE: begin
          ct_reg   <= data_reg;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready_out     = (state_reg == IDLE);
  assign done_out      = done_reg;
  assign ke_count_out  = round_reg;
  assign ke_data_out_0 = key_reg[BW-1 -: DATA_WIDTH];
  assign ke_data_out_1 = key_reg[BW-1-DATA_WIDTH -: DATA_WIDTH];
  assign ke_data_out_2 = key_reg[BW-1-2*DATA_WIDTH -: DATA_WIDTH];
  assign ke_data_out_3 = key_reg[DATA_WIDTH-1:0];
  assign ct_out_0      = ct_reg[BW-1 -: DATA_WIDTH];
  assign ct_out_1      = ct_reg[BW-1-DATA_WIDTH -: DATA_WIDTH];
  assign ct_out_2      = ct_reg[BW-1-2*DATA_WIDTH -: DATA_WIDTH];
  assign ct_out_3      = ct_reg[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core with a behavioural Key_Expansion (one registered cycle
// from ke_count_out to rk_in) and FIPS-197 known-answer vectors.
module tb_aes_cipher_core;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_in = 1'b0;
  logic [127:0] pt_v = '0;
  logic [127:0] key_v = '0;
  logic [127:0] rk_v = '0;
  logic [127:0] ke_key = '0;
  logic [2:0]   ke_fsm_out;
  logic [3:0]   ke_count_out;
  logic [31:0]  ke_data_out_0, ke_data_out_1, ke_data_out_2, ke_data_out_3;
  logic         ready_out, done_out;
  logic [31:0]  ct_out_0, ct_out_1, ct_out_2, ct_out_3;
  logic [127:0] ct_w, kd_w;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  start_pending = 0;
  vec_t vecs [2];

  always #5 clk = ~clk;

  aes_cipher_core #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in),
    .pt_in_0(pt_v[127:96]), .pt_in_1(pt_v[95:64]), .pt_in_2(pt_v[63:32]), .pt_in_3(pt_v[31:0]),
    .key_in_0(key_v[127:96]), .key_in_1(key_v[95:64]), .key_in_2(key_v[63:32]), .key_in_3(key_v[31:0]),
    .rk_in_0(rk_v[127:96]), .rk_in_1(rk_v[95:64]), .rk_in_2(rk_v[63:32]), .rk_in_3(rk_v[31:0]),
    .ke_fsm_out(ke_fsm_out), .ke_count_out(ke_count_out),
    .ke_data_out_0(ke_data_out_0), .ke_data_out_1(ke_data_out_1),
    .ke_data_out_2(ke_data_out_2), .ke_data_out_3(ke_data_out_3),
    .ready_out(ready_out), .done_out(done_out),
    .ct_out_0(ct_out_0), .ct_out_1(ct_out_1), .ct_out_2(ct_out_2), .ct_out_3(ct_out_3)
  );

  assign ct_w = {ct_out_0, ct_out_1, ct_out_2, ct_out_3};
  assign kd_w = {ke_data_out_0, ke_data_out_1, ke_data_out_2, ke_data_out_3};

  function automatic logic [127:0] round_key(input logic [127:0] k, input logic [3:0] n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    int          b;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = aes_pkg::sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = aes_pkg::xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    b = (n > 4'd10) ? 0 : 4 * int'(n);
    return {w[b], w[b+1], w[b+2], w[b+3]};
  endfunction

  always @(posedge clk) begin
    if (ke_fsm_out == 3'b001) ke_key <= kd_w;
    rk_v <= round_key(ke_key, ke_count_out);
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready"}, 128'(ready_out), 128'd1);
    check({tag, " done"}, 128'(done_out), 128'd0);
    check({tag, " ct"}, ct_w, 128'd0);
    check({tag, " ke_fsm"}, 128'(ke_fsm_out), 128'd0);
    check({tag, " ke_count"}, 128'(ke_count_out), 128'd0);
    check({tag, " ke_data"}, kd_w, 128'd0);
  endtask

  // spam: new random start/key/pt every busy cycle; chain: arm next vector in DONE cycle;
  // abort_at: assert reset at that cycle index and return.
  task automatic run_block(input string tag, input vec_t v, input bit spam, input bit chain,
                           input vec_t nv, input int abort_at);
    int edges;
    logic [127:0] hold_ct;
    logic [2:0] efsm;
    logic [3:0] ecnt;
    if (!start_pending) begin
      @(negedge clk);
      key_v = v.key; pt_v = v.pt; start_in = 1'b1;
    end
    start_pending = 0;
    hold_ct = ct_w;
    check({tag, " ready_at_start"}, 128'(ready_out), 128'd1);
    @(posedge clk);
    @(negedge clk);
    start_in = 1'b0;
    edges = 0;
    while (!done_out && edges < 60) begin
      if (edges == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs({tag, " async_reset"});
        return;
      end
      if (edges <= 23) begin
        efsm = (edges == 0) ? 3'b001 : (edges <= 22) ? 3'b010 : 3'b000;
        ecnt = (edges >= 1 && edges <= 22) ? 4'((edges - 1) / 2) : 4'd0;
        check($sformatf("%s ke_fsm@%0d", tag, edges), 128'(ke_fsm_out), 128'(efsm));
        check($sformatf("%s ke_count@%0d", tag, edges), 128'(ke_count_out), 128'(ecnt));
        check($sformatf("%s busy@%0d", tag, edges), 128'(ready_out), 128'd0);
        check($sformatf("%s ct_hold@%0d", tag, edges), ct_w, hold_ct);
        check($sformatf("%s ke_data@%0d", tag, edges), kd_w, v.key);
      end
      if (spam) begin
        start_in = 1'b1;
        key_v = {$urandom(), $urandom(), $urandom(), $urandom()};
        pt_v  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (chain && edges == 23) begin
        start_in = 1'b1; key_v = nv.key; pt_v = nv.pt;
      end
      edges++;
      @(negedge clk);
    end
    if (!chain) start_in = 1'b0;
    check({tag, " latency"}, 128'(edges), 128'd24);
    check({tag, " done"}, 128'(done_out), 128'd1);
    check({tag, " ct"}, ct_w, v.ct);
    $display("%s: key %h pt %h -> ct %h (latency %0d)", tag, v.key, v.pt, ct_w, edges);
    if (chain) begin
      start_pending = 1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check($sformatf("%s done_low+%0d", tag, i), 128'(done_out), 128'd0);
        check($sformatf("%s idle+%0d", tag, i), 128'(ready_out), 128'd1);
        check($sformatf("%s ct_kept+%0d", tag, i), ct_w, v.ct);
      end
    end
  endtask

  initial begin
    vec_t none;
    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                pt:  128'h00112233445566778899aabbccddeeff,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    none = vecs[0];

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    $display("reset: outputs at reset values checked");
    rst_n = 1'b1;

    for (int i = 0; i < 2; i++)
      run_block($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0, none, -1);

    run_block("busy_spam", vecs[0], 1'b1, 1'b0, none, -1);

    run_block("abort", vecs[1], 1'b0, 1'b0, none, 12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort no_done+%0d", i), 128'(done_out), 128'd0);
      check($sformatf("abort ct_clear+%0d", i), ct_w, 128'd0);
    end
    rst_n = 1'b1;
    $display("abort: reset at round 5 checked");
    run_block("after_abort", vecs[1], 1'b0, 1'b0, none, -1);

    run_block("b2b_first", vecs[0], 1'b0, 1'b1, vecs[1], -1);
    run_block("b2b_second", vecs[1], 1'b0, 1'b0, none, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_cipher_core.md
Name: aes_cipher_core

Overview:
Iterative AES-128 encryption datapath and round controller. Sits directly downstream of Key_Expansion and also drives its control inputs: it forwards the cipher key, sequences FSM_core_in and core_count_in, and consumes one 128-bit round key per round. It performs AddRoundKey, SubBytes, ShiftRows and MixColumns on a 128-bit state register and returns the ciphertext with a ready/start/done handshake.

Parameters:
DATA_WIDTH, 32, word width; the state and keys are 4 words of DATA_WIDTH. Only 32 is supported.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_in  in  1  request; accepted only when ready_out=1
pt_in_0..pt_in_3  in  32 each  plaintext words; word 0 = bytes 0-3, MSB first
key_in_0..key_in_3  in  32 each  cipher key words, sampled with start_in
rk_in_0..rk_in_3  in  32 each  round key from Key_Expansion data_out_0..3
ke_fsm_out  out  3  drives Key_Expansion FSM_core_in
ke_count_out  out  4  drives Key_Expansion core_count_in
ke_data_out_0..3  out  32 each  drives Key_Expansion data_in_0..3 (latched cipher key)
ready_out  out  1  high in IDLE only
done_out  out  1  one-cycle pulse when ct_out is valid
ct_out_0..ct_out_3  out  32 each  ciphertext, held until the next done_out

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low, and returns the block to IDLE.
- Reset values: state=IDLE, ke_fsm_out=000, ke_count_out=0, ke_data_out=0, ready_out=1, done_out=0, ct_out=0, state register=0, round counter=0.
- States and encodings:
  - IDLE 000: ke_fsm_out=000. On start_in, latch pt_in into the state register and key_in into ke_data_out, then go to LOAD.
  - LOAD 001: one cycle. ke_fsm_out=001, ke_count_out=0; Key_Expansion captures the cipher key. Go to KWAIT.
  - KWAIT 010: one cycle. ke_fsm_out=010. Round key r settles on rk_in, because Key_Expansion has one registered cycle of latency from ke_count_out. Go to ROUND.
  - ROUND 011: one cycle. ke_fsm_out=010. Apply round r using rk_in:
    - r=0: state ^= rk.
    - r=1..9: state = MixColumns(ShiftRows(SubBytes(state))) ^ rk.
    - r=10: state = ShiftRows(SubBytes(state)) ^ rk.
    - If r<10: r++, ke_count_out=r+1, go to KWAIT. If r=10: go to DONE.
  - DONE 100: one cycle. ct_out <= state, done_out=1, ke_fsm_out=000, ke_count_out=0. Go to IDLE.
- Latency: start accepted at edge T, done_out high in the cycle after edge T+24, i.e. 1 LOAD + 11 x (KWAIT+ROUND) + 1 DONE. Throughput is one block per 25 cycles.
- ke_count_out only changes on the ROUND->KWAIT transition, so it is stable for 2 cycles per round and never exceeds 10.
- ke_data_out holds the latched key for the whole operation. A change on key_in while busy has no effect.
- start_in while ready_out=0 is ignored, not queued. start_in in the DONE cycle is ignored; the earliest new accept is the cycle after done_out.
- Arithmetic: all GF(2^8) with reduction polynomial 0x11B. MixColumns uses xtime. Byte order is FIPS-197 column-major: word i = column i.
- Reset asserted mid-operation: immediate return to reset values. No done_out, and ct_out is cleared.

Decomposition:
- Package aes_pkg:
  - state-encoding typedef (IDLE/LOAD/KWAIT/ROUND/DONE with the values above)
  - constants NUM_ROUNDS=10 and KE_LOAD=3'b001, KE_RUN=3'b010
  - 256-entry SBOX constant
  - functions xtime, sub_word, mix_column
- One sub-module, aes_round_comb: combinational SubBytes/ShiftRows/optional MixColumns on 128 bits, with a final_round select. aes_cipher_core contains the FSM, counter, registers and handshake.

Test Plan:
1. Integrate with Key_Expansion. Key 2b7e1516 28aed2a6 abf71588 09cf4f3c, pt 3243f6a8 885a308d 313198a2 e0370734 -> ct 3925841d 02dc09fb dc118597 196a0b32; done_out 24 cycles after the start edge, one cycle wide.
2. Key 00010203 04050607 08090a0b 0c0d0e0f, pt 00112233 44556677 8899aabb ccddeeff -> ct 69c4e0d8 6a7b0430 d8cdb780 70b4c55a.
3. Protocol check: ke_fsm_out sequence 001, then 010 for 22 cycles, then 000. ke_count_out steps 0..10, each value held exactly 2 cycles.
4. Assert start_in with a different pt/key every cycle while busy -> ready_out=0 throughout, result still equals test 1, exactly one done_out.
5. Assert rst_n=0 at round 5 -> all outputs at reset values within the same cycle, no done_out. After release, rerunning test 2 gives the correct ct.
6. Back-to-back runs of tests 1 and 2 with start_in asserted in the DONE cycle -> that start is ignored. The next start, one cycle later, is accepted, and ct_out holds the test 1 result until the second done_out.
